datapath_state_registers: RTL and testbench

Sequential state and operand-select slice of the 16-bit CPU datapath: program counter register, instruction register, ALU result register and the ALU B-operand 2:1 select. Built from three reusable primitives (`flop_enable_reset`, `flop_reset`, `mux2`), which are instantiated here and also used elsewhere in the datapath. Sits between memory/ALU outputs and the register file/ALU inputs.

---
 rtl/datapath_state_registers.sv | 93 +++++++++
 tb/tb_datapath_state_registers.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_state_registers.sv
// datapath_state_registers: PC, IR and ALU result registers plus the ALU B-operand select

// flop_enable_reset: register with load enable and asynchronous active-high clear
module flop_enable_reset #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // reset clears at once; otherwise load on enabled rising edges and hold between them
    always_ff @(posedge clock or posedge reset)
        if (reset) q <= '0;
        else if (enable) q <= d;
endmodule

// flop_reset: register loading every cycle with asynchronous active-high clear
module flop_reset #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // reset clears at once; otherwise capture d on every rising edge
    always_ff @(posedge clock or posedge reset)
        if (reset) q <= '0;
        else q <= d;
endmodule

// mux2: combinational two-input select; an unknown select yields unknown bits
module mux2 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             select,
    output logic [WIDTH-1:0] y
);
    assign y = select ? d1 : d0;
endmodule

module datapath_state_registers #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] B_CONSTANT = WIDTH'(1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             program_counter_write_enable,
    input  logic [WIDTH-1:0] next_program_counter,
    input  logic             instruction_write_enable,
    input  logic [WIDTH-1:0] memory_read_data,
    input  logic [WIDTH-1:0] alu_d,
    input  logic [WIDTH-1:0] destination,
    input  logic             alu_b_select,
    output logic [WIDTH-1:0] program_counter,
    output logic [WIDTH-1:0] instruction,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] alu_b
);
    flop_enable_reset #(.WIDTH(WIDTH)) pc_reg (
        .clock (clock),
        .reset (reset),
        .enable(program_counter_write_enable),
        .d     (next_program_counter),
        .q     (program_counter)
    );

    flop_enable_reset #(.WIDTH(WIDTH)) ir_reg (
        .clock (clock),
        .reset (reset),
        .enable(instruction_write_enable),
        .d     (memory_read_data),
        .q     (instruction)
    );

    flop_reset #(.WIDTH(WIDTH)) result_reg (
        .clock(clock),
        .reset(reset),
        .d    (alu_d),
        .q    (result)
    );

    mux2 #(.WIDTH(WIDTH)) b_mux (
        .d0    (destination),
        .d1    (B_CONSTANT),
        .select(alu_b_select),
        .y     (alu_b)
    );
endmodule

// File: tb/tb_datapath_state_registers.sv
// tb_datapath_state_registers: directed checks of the datapath state registers and B-operand select
module tb_datapath_state_registers;
    logic        clock = 1'b0;
    logic        reset;
    logic        program_counter_write_enable;
    logic [15:0] next_program_counter;
    logic        instruction_write_enable;
    logic [15:0] memory_read_data;
    logic [15:0] alu_d;
    logic [15:0] destination;
    logic        alu_b_select;
    logic [15:0] program_counter;
    logic [15:0] instruction;
    logic [15:0] result;
    logic [15:0] alu_b;
    int          assertions = 0;
    int          failures = 0;

    datapath_state_registers dut (
        .clock                       (clock),
        .reset                       (reset),
        .program_counter_write_enable(program_counter_write_enable),
        .next_program_counter        (next_program_counter),
        .instruction_write_enable    (instruction_write_enable),
        .memory_read_data            (memory_read_data),
        .alu_d                       (alu_d),
        .destination                 (destination),
        .alu_b_select                (alu_b_select),
        .program_counter             (program_counter),
        .instruction                 (instruction),
        .result                      (result),
        .alu_b                       (alu_b)
    );

    always #5 clock = ~clock;

    task automatic edge_settle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        program_counter_write_enable = 1'b0;
        instruction_write_enable = 1'b0;
        next_program_counter = 16'h0;
        memory_read_data = 16'h0;
        alu_d = 16'h0;
        destination = 16'h2468;
        alu_b_select = 1'b0;
        #2;
        assertions++;
        if (program_counter !== 16'h0 || instruction !== 16'h0 || result !== 16'h0) begin
            failures++;
            $display("FAIL initial_reset: pc=%h ir=%h res=%h, required all 0000", program_counter, instruction, result);
        end
        assertions++;
        if (alu_b !== 16'h2468) begin
            failures++;
            $display("FAIL mux_during_reset: alu_b=%h, required 2468", alu_b);
        end
        @(negedge clock);
        reset = 1'b0;
        program_counter_write_enable = 1'b1;
        instruction_write_enable = 1'b1;
        next_program_counter = 16'h1234;
        memory_read_data = 16'hABCD;
        alu_d = 16'h5555;
        edge_settle();
        assertions++;
        if (program_counter !== 16'h1234 || instruction !== 16'hABCD || result !== 16'h5555) begin
            failures++;
            $display("FAIL preload: pc=%h ir=%h res=%h, required 1234 abcd 5555", program_counter, instruction, result);
        end
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        assertions++;
        if (program_counter !== 16'h0 || instruction !== 16'h0 || result !== 16'h0) begin
            failures++;
            $display("FAIL async_reset: pc=%h ir=%h res=%h, required all 0000", program_counter, instruction, result);
        end
        repeat (2) begin
            edge_settle();
            assertions++;
            if (program_counter !== 16'h0 || instruction !== 16'h0 || result !== 16'h0) begin
                failures++;
                $display("FAIL reset_hold: pc=%h ir=%h res=%h, required all 0000", program_counter, instruction, result);
            end
        end
        @(negedge clock);
        reset = 1'b0;
        program_counter_write_enable = 1'b0;
        instruction_write_enable = 1'b0;
        alu_d = 16'h0;
    endtask

    task automatic test_pc_enable();
        @(negedge clock);
        next_program_counter = 16'h0001;
        program_counter_write_enable = 1'b1;
        edge_settle();
        assertions++;
        if (program_counter !== 16'h0001) begin
            failures++;
            $display("FAIL pc_load: pc=%h, required 0001", program_counter);
        end
        @(negedge clock);
        next_program_counter = 16'h00FF;
        program_counter_write_enable = 1'b0;
        repeat (3) begin
            edge_settle();
            assertions++;
            if (program_counter !== 16'h0001) begin
                failures++;
                $display("FAIL pc_hold: pc=%h, required 0001", program_counter);
            end
        end
        @(negedge clock);
        program_counter_write_enable = 1'b1;
        #1;
        program_counter_write_enable = 1'b0;
        edge_settle();
        assertions++;
        if (program_counter !== 16'h0001) begin
            failures++;
            $display("FAIL pc_enable_glitch: pc=%h, required 0001", program_counter);
        end
        @(negedge clock);
        program_counter_write_enable = 1'b1;
        edge_settle();
        assertions++;
        if (program_counter !== 16'h00FF) begin
            failures++;
            $display("FAIL pc_reload: pc=%h, required 00ff", program_counter);
        end
        @(negedge clock);
        program_counter_write_enable = 1'b0;
    endtask

    task automatic test_ir_enable();
        @(negedge clock);
        next_program_counter = 16'h0AAA;
        memory_read_data = 16'hF00D;
        instruction_write_enable = 1'b1;
        edge_settle();
        assertions++;
        if (instruction !== 16'hF00D || program_counter !== 16'h00FF) begin
            failures++;
            $display("FAIL ir_only: ir=%h pc=%h, required f00d 00ff", instruction, program_counter);
        end
        @(negedge clock);
        next_program_counter = 16'h0100;
        memory_read_data = 16'hBEEF;
        program_counter_write_enable = 1'b1;
        edge_settle();
        assertions++;
        if (instruction !== 16'hBEEF || program_counter !== 16'h0100) begin
            failures++;
            $display("FAIL both_load: ir=%h pc=%h, required beef 0100", instruction, program_counter);
        end
        @(negedge clock);
        memory_read_data = 16'h1111;
        program_counter_write_enable = 1'b0;
        instruction_write_enable = 1'b0;
        edge_settle();
        assertions++;
        if (instruction !== 16'hBEEF) begin
            failures++;
            $display("FAIL ir_hold: ir=%h, required beef", instruction);
        end
    endtask

    task automatic test_result();
        logic [15:0] seq [3] = '{16'h0003, 16'hFFFF, 16'h8000};
        logic [15:0] prev = result;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            alu_d = seq[i];
            #1;
            assertions++;
            if (result !== prev) begin
                failures++;
                $display("FAIL result_before_edge[%0d]: res=%h, required %h", i, result, prev);
            end
            edge_settle();
            assertions++;
            if (result !== seq[i]) begin
                failures++;
                $display("FAIL result_follow[%0d]: res=%h, required %h", i, result, seq[i]);
            end
            prev = seq[i];
        end
    endtask

    task automatic test_mux();
        @(negedge clock);
        #1;
        destination = 16'h7E7E;
        alu_b_select = 1'b0;
        #1;
        assertions++;
        if (alu_b !== 16'h7E7E) begin
            failures++;
            $display("FAIL mux_sel0: alu_b=%h, required 7e7e", alu_b);
        end
        alu_b_select = 1'b1;
        #1;
        assertions++;
        if (alu_b !== 16'h0001) begin
            failures++;
            $display("FAIL mux_sel1: alu_b=%h, required 0001", alu_b);
        end
        destination = 16'h8181;
        #1;
        assertions++;
        if (alu_b !== 16'h0001) begin
            failures++;
            $display("FAIL mux_sel1_toggle: alu_b=%h, required 0001", alu_b);
        end
        alu_b_select = 1'b0;
        #1;
        assertions++;
        if (alu_b !== 16'h8181) begin
            failures++;
            $display("FAIL mux_back_sel0: alu_b=%h, required 8181", alu_b);
        end
    endtask

    task automatic test_reset_release();
        @(negedge clock);
        reset = 1'b1;
        next_program_counter = 16'h0042;
        program_counter_write_enable = 1'b1;
        #1;
        assertions++;
        if (program_counter !== 16'h0) begin
            failures++;
            $display("FAIL release_in_reset: pc=%h, required 0000", program_counter);
        end
        @(negedge clock);
        #3;
        reset = 1'b0;
        edge_settle();
        assertions++;
        if (program_counter !== 16'h0042) begin
            failures++;
            $display("FAIL release_first_load: pc=%h, required 0042", program_counter);
        end
        @(negedge clock);
        program_counter_write_enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pc_enable();
        test_ir_enable();
        test_result();
        test_mux();
        test_reset_release();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
